// File: rtl/coil_stage_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// coil_stage_sequencer : edge-triggered CHARGE -> FIRE/GAP x N -> COOLDOWN
// launcher sequencer with integrated PWM gating of the stage fire outputs.
// Revision 1.0
// ---------------------------------------------------------------------------
module coil_stage_sequencer #(
  parameter int NUM_STAGES      = 4,
  parameter int CNT_W           = 32,
  parameter int DUTY_W          = 32,
  parameter int PWM_PERIOD      = 588000,
  parameter int CHARGE_CYCLES   = 100000000,
  parameter int FIRE_CYCLES     = 50000,
  parameter int GAP_CYCLES      = 10000,
  parameter int COOLDOWN_CYCLES = 1000000,
  localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trig,
  input  logic                  abort,
  input  logic [DUTY_W-1:0]     duty_idle,
  input  logic [DUTY_W-1:0]     duty_fire,
  output logic                  charge_n,
  output logic [NUM_STAGES-1:0] fire,
  output logic                  pwm_out,
  output logic                  busy,
  output logic [SW-1:0]         stage_idx,
  output logic                  done
);

  localparam longint CNT_MAX  = (CNT_W  >= 63) ? 64'sh7FFF_FFFF_FFFF_FFFF
                                               : ((longint'(1) << CNT_W) - longint'(1));
  localparam longint DUTY_MAX = (DUTY_W >= 63) ? 64'sh7FFF_FFFF_FFFF_FFFF
                                               : ((longint'(1) << DUTY_W) - longint'(1));

  if (NUM_STAGES < 1 || PWM_PERIOD < 2 || CHARGE_CYCLES < 1 || FIRE_CYCLES < 1 ||
      GAP_CYCLES < 1 || COOLDOWN_CYCLES < 1) begin : g_bad_range
    $error("coil_stage_sequencer: parameter below its minimum");
  end

  if (longint'(CHARGE_CYCLES) > CNT_MAX || longint'(FIRE_CYCLES) > CNT_MAX ||
      longint'(GAP_CYCLES) > CNT_MAX || longint'(COOLDOWN_CYCLES) > CNT_MAX ||
      longint'(PWM_PERIOD) > DUTY_MAX) begin : g_bad_width
    $error("coil_stage_sequencer: parameter does not fit its counter width");
  end

  localparam logic [CNT_W-1:0]  CHARGE_LOAD = CNT_W'(CHARGE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  FIRE_LOAD   = CNT_W'(FIRE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD    = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  COOL_LOAD   = CNT_W'(COOLDOWN_CYCLES - 1);
  localparam logic [DUTY_W-1:0] PWM_LAST    = DUTY_W'(PWM_PERIOD - 1);
  localparam logic [SW-1:0]     LAST_STAGE  = SW'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CHARGE   = 3'd1,
    S_FIRE     = 3'd2,
    S_GAP      = 3'd3,
    S_COOLDOWN = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    timer, timer_nxt;
  logic [SW-1:0]       stage_nxt;
  logic                done_nxt;
  logic                trig_q;
  logic [DUTY_W-1:0]   pwm_cnt, pwm_cnt_nxt;
  logic [DUTY_W-1:0]   duty_q, duty_nxt;
  logic                start;
  logic                expired;
  logic                pwm_wrap;

  assign start    = trig & ~trig_q & (state == S_IDLE) & ~abort;
  assign expired  = (timer == '0);
  assign pwm_wrap = (pwm_cnt == PWM_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      timer     <= '0;
      stage_idx <= '0;
      done      <= 1'b0;
      trig_q    <= 1'b0;
      pwm_cnt   <= '0;
      duty_q    <= '0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      stage_idx <= stage_nxt;
      done      <= done_nxt;
      trig_q    <= trig;
      pwm_cnt   <= pwm_cnt_nxt;
      duty_q    <= duty_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    stage_nxt   = stage_idx;
    done_nxt    = 1'b0;
    pwm_cnt_nxt = pwm_wrap ? '0 : pwm_cnt + DUTY_W'(1);
    duty_nxt    = pwm_wrap ? ((state == S_FIRE) ? duty_fire : duty_idle) : duty_q;

    if (abort) begin
      state_nxt   = S_IDLE;
      timer_nxt   = '0;
      stage_nxt   = '0;
      pwm_cnt_nxt = '0;
      duty_nxt    = duty_idle;
    end else begin
      // FIRE entry and exit restart the PWM period so every stage gets a full first period.
      case (state)
        S_IDLE: begin
          if (start) begin
            state_nxt = S_CHARGE;
            timer_nxt = CHARGE_LOAD;
          end
        end
        S_CHARGE: begin
          if (expired) begin
            state_nxt   = S_FIRE;
            timer_nxt   = FIRE_LOAD;
            stage_nxt   = '0;
            pwm_cnt_nxt = '0;
            duty_nxt    = duty_fire;
          end else begin
            timer_nxt = timer - CNT_W'(1);
          end
        end
        S_FIRE: begin
          if (expired) begin
            state_nxt   = (stage_idx == LAST_STAGE) ? S_COOLDOWN : S_GAP;
            timer_nxt   = (stage_idx == LAST_STAGE) ? COOL_LOAD : GAP_LOAD;
            pwm_cnt_nxt = '0;
            duty_nxt    = duty_idle;
          end else begin
            timer_nxt = timer - CNT_W'(1);
          end
        end
        S_GAP: begin
          if (expired) begin
            state_nxt   = S_FIRE;
            timer_nxt   = FIRE_LOAD;
            stage_nxt   = stage_idx + SW'(1);
            pwm_cnt_nxt = '0;
            duty_nxt    = duty_fire;
          end else begin
            timer_nxt = timer - CNT_W'(1);
          end
        end
        S_COOLDOWN: begin
          if (expired) begin
            state_nxt = S_IDLE;
            timer_nxt = '0;
            stage_nxt = '0;
            done_nxt  = 1'b1;
          end else begin
            timer_nxt = timer - CNT_W'(1);
          end
        end
        default: begin
          state_nxt = S_IDLE;
          timer_nxt = '0;
          stage_nxt = '0;
        end
      endcase
    end
  end

  assign charge_n = (state != S_CHARGE);
  assign busy     = (state != S_IDLE);
  assign pwm_out  = (pwm_cnt < duty_q);

  always_comb begin
    for (int i = 0; i < NUM_STAGES; i++) begin
      fire[i] = pwm_out && (state == S_FIRE) && (stage_idx == SW'(i));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_coil_stage_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_coil_stage_sequencer : timeline-based reference model plus directed and
// randomized stimulus for coil_stage_sequencer.  Revision 1.0
// ---------------------------------------------------------------------------
module tb_coil_stage_sequencer;

  localparam int N     = 3;
  localparam int CH    = 10;
  localparam int FI    = 4;
  localparam int GA    = 2;
  localparam int CD    = 5;
  localparam int PP    = 8;
  localparam int TOTAL = CH + N*FI + (N-1)*GA + CD;

  localparam int PH_IDLE   = 0;
  localparam int PH_CHARGE = 1;
  localparam int PH_FIRE   = 2;
  localparam int PH_GAP    = 3;
  localparam int PH_COOL   = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         trig = 1'b0;
  logic         abort = 1'b0;
  logic [7:0]   duty_idle = 8'd0;
  logic [7:0]   duty_fire = 8'd8;
  logic         charge_n;
  logic [N-1:0] fire;
  logic         pwm_out;
  logic         busy;
  logic [1:0]   stage_idx;
  logic         done;

  coil_stage_sequencer #(
    .NUM_STAGES(N), .CNT_W(16), .DUTY_W(8), .PWM_PERIOD(PP),
    .CHARGE_CYCLES(CH), .FIRE_CYCLES(FI), .GAP_CYCLES(GA), .COOLDOWN_CYCLES(CD)
  ) dut (
    .clk(clk), .rst(rst), .trig(trig), .abort(abort),
    .duty_idle(duty_idle), .duty_fire(duty_fire),
    .charge_n(charge_n), .fire(fire), .pwm_out(pwm_out),
    .busy(busy), .stage_idx(stage_idx), .done(done)
  );

  always #5 clk = ~clk;

  // Model: a launch is a position on a fixed timeline of TOTAL cycles.
  bit m_active    = 1'b0;
  int m_pos       = 0;
  bit m_trig_prev = 1'b0;
  int m_pc        = 0;
  int m_dq        = 0;
  bit m_done      = 1'b0;

  function automatic int phase_of(bit act, int pos);
    int r;
    if (!act) return PH_IDLE;
    if (pos < CH) return PH_CHARGE;
    r = pos - CH;
    if (r >= N*FI + (N-1)*GA) return PH_COOL;
    return ((r % (FI+GA)) < FI) ? PH_FIRE : PH_GAP;
  endfunction

  function automatic int stage_of(bit act, int pos);
    int k;
    if (!act || pos < CH) return 0;
    k = (pos - CH) / (FI+GA);
    return (k > N-1) ? N-1 : k;
  endfunction

  always @(posedge clk or posedge rst) begin : mdl
    int  cph, nph, npos, npc, ndq;
    bit  nact, ndone;
    if (rst) begin
      m_active    <= 1'b0;
      m_pos       <= 0;
      m_trig_prev <= 1'b0;
      m_pc        <= 0;
      m_dq        <= 0;
      m_done      <= 1'b0;
    end else begin
      cph   = phase_of(m_active, m_pos);
      nact  = m_active;
      npos  = m_pos;
      ndone = 1'b0;
      if (abort) begin
        nact = 1'b0; npos = 0;
      end else if (m_active) begin
        if (m_pos == TOTAL-1) begin nact = 1'b0; npos = 0; ndone = 1'b1; end
        else npos = m_pos + 1;
      end else if (trig && !m_trig_prev) begin
        nact = 1'b1; npos = 0;
      end
      nph = phase_of(nact, npos);
      if (abort) begin
        npc = 0; ndq = int'(duty_idle);
      end else if ((cph == PH_FIRE) != (nph == PH_FIRE)) begin
        npc = 0; ndq = (nph == PH_FIRE) ? int'(duty_fire) : int'(duty_idle);
      end else if (m_pc == PP-1) begin
        npc = 0; ndq = (cph == PH_FIRE) ? int'(duty_fire) : int'(duty_idle);
      end else begin
        npc = m_pc + 1; ndq = m_dq;
      end
      m_active    <= nact;
      m_pos       <= npos;
      m_done      <= ndone;
      m_pc        <= npc;
      m_dq        <= ndq;
      m_trig_prev <= trig;
    end
  end

  function automatic logic [8:0] expected();
    int           ph;
    int           st;
    bit           pw;
    logic [N-1:0] f;
    ph = phase_of(m_active, m_pos);
    st = stage_of(m_active, m_pos);
    pw = (m_pc < m_dq);
    f  = '0;
    if (ph == PH_FIRE && pw) f[st] = 1'b1;
    return {ph != PH_CHARGE, f, pw, m_active, 2'(st), m_done};
  endfunction

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int busy_cnt, charge_cnt, done_cnt, pwm_hi, last_busy_cyc, done_cyc;
  int fire_cnt [N];

  task automatic clr();
    busy_cnt = 0; charge_cnt = 0; done_cnt = 0; pwm_hi = 0;
    last_busy_cyc = -1; done_cyc = -1;
    for (int i = 0; i < N; i++) fire_cnt[i] = 0;
  endtask

  task automatic lit(string name, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Every-cycle compare of all outputs against the model, at the falling edge.
  task automatic step();
    logic [8:0] act, exp_v;
    @(negedge clk);
    cyc++;
    if (!rst) begin
      act   = {charge_n, fire, pwm_out, busy, stage_idx, done};
      exp_v = expected();
      total++;
      if (act !== exp_v) begin
        bad++;
        $display("FAIL outputs t=%0t {charge_n,fire,pwm,busy,stage,done} got %b want %b",
                 $time, act, exp_v);
      end
      if (busy) begin busy_cnt++; last_busy_cyc = cyc; end
      if (!charge_n) charge_cnt++;
      if (pwm_out) pwm_hi++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      for (int i = 0; i < N; i++) if (fire[i]) fire_cnt[i]++;
    end
    #2;
  endtask

  task automatic launch();
    trig = 1'b1;
    step();
    trig = 1'b0;
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    step();
    trig = 1'b0;
  endtask

  task automatic wait_done(int budget);
    int d0;
    d0 = done_cnt;
    for (int k = 0; k < budget; k++) begin
      step();
      if (done_cnt != d0) return;
    end
    total++; bad++;
    $display("FAIL wait_done: got no done want done within %0d cycles", budget);
  endtask

  initial begin
    #1;
    lit("reset_outputs", int'({charge_n, fire, pwm_out, busy, stage_idx, done}), 9'b1_000_0_0_00_0);
    repeat (3) step();
    rst = 1'b0;
    repeat (3) step();

    // 1: single pulse, full-duty fire
    clr();
    launch();
    wait_done(60);
    lit("t1_busy_len", busy_cnt, 31);
    lit("t1_charge_len", charge_cnt, 10);
    lit("t1_fire0", fire_cnt[0], 4);
    lit("t1_fire1", fire_cnt[1], 4);
    lit("t1_fire2", fire_cnt[2], 4);
    lit("t1_done_cnt", done_cnt, 1);
    lit("t1_done_after_busy", done_cyc - last_busy_cyc, 1);
    repeat (3) step();

    // 2: held trigger gives one launch; a fresh edge gives another
    clr();
    trig = 1'b1;
    repeat (100) step();
    lit("t2_held_done", done_cnt, 1);
    lit("t2_held_busy", busy_cnt, 31);
    trig = 1'b0;
    step();
    clr();
    trig = 1'b1;
    wait_done(60);
    lit("t2_second_done", done_cnt, 1);
    trig = 1'b0;
    repeat (3) step();

    // 3: edges during CHARGE, FIRE and COOLDOWN are dropped
    clr();
    launch();
    repeat (3) step();
    pulse_trig();
    repeat (8) step();
    pulse_trig();
    repeat (13) step();
    pulse_trig();
    repeat (40) step();
    lit("t3_done_cnt", done_cnt, 1);
    lit("t3_busy_len", busy_cnt, 31);

    // 4: partial duty, idle duty changes
    duty_fire = 8'd3;
    clr();
    launch();
    wait_done(60);
    lit("t4_fire0", fire_cnt[0], 3);
    lit("t4_fire1", fire_cnt[1], 3);
    lit("t4_fire2", fire_cnt[2], 3);
    duty_idle = 8'd2;
    repeat (11) step();
    duty_idle = 8'd6;
    repeat (20) step();
    duty_idle = 8'd0;
    repeat (10) step();
    clr();
    repeat (16) step();
    lit("t4_idle_pwm_zero", pwm_hi, 0);

    // 5: abort in the second cycle of stage 1 FIRE, then relaunch; abort vs start
    duty_fire = 8'd8;
    clr();
    launch();
    for (int k = 0; k < 40 && !(m_active && m_pos == CH+FI+GA+1); k++) step();
    lit("t5_reached_stage1", int'(m_active && m_pos == CH+FI+GA+1), 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    lit("t5_busy_after_abort", int'(busy), 0);
    lit("t5_fire_after_abort", int'(fire), 0);
    lit("t5_stage_after_abort", int'(stage_idx), 0);
    repeat (40) step();
    lit("t5_no_done", done_cnt, 0);
    clr();
    launch();
    wait_done(60);
    lit("t5_relaunch_done", done_cnt, 1);
    step();
    clr();
    trig = 1'b1; abort = 1'b1;
    step();
    abort = 1'b0;
    repeat (5) step();
    lit("t5_abort_blocks_start", busy_cnt, 0);
    trig = 1'b0;
    step();

    // 6: asynchronous reset mid-CHARGE
    duty_idle = 8'd8;
    repeat (10) step();
    clr();
    launch();
    repeat (4) step();
    lit("t6_pre_charge_n", int'(charge_n), 0);
    lit("t6_pre_pwm", int'(pwm_out), 1);
    #1 rst = 1'b1;
    #1;
    lit("t6_async_charge_n", int'(charge_n), 1);
    lit("t6_async_busy", int'(busy), 0);
    lit("t6_async_pwm", int'(pwm_out), 0);
    repeat (3) step();
    rst = 1'b0;
    clr();
    repeat (40) step();
    lit("t6_no_pending_launch", busy_cnt, 0);

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 5) == 0) trig = ~trig;
      abort = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 49) == 0) duty_fire = 8'($urandom_range(0, 9));
      if ($urandom_range(0, 49) == 0) duty_idle = 8'($urandom_range(0, 9));
      step();
    end
    abort = 1'b0;
    trig  = 1'b0;
    repeat (40) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/coil_stage_sequencer.md
Name: coil_stage_sequencer

Overview:
Multi-stage coil launcher controller.
- A trigger edge starts a shared charge phase.
- Stages then fire in order 0..NUM_STAGES-1. Each stage's fire output is PWM-gated, and a programmable gap separates consecutive stages.
- A cooldown phase follows before the next launch is accepted.
- Sits between pushbutton/trigger logic and the coil driver pins.
- Integrates the PWM generator and fixes single-shot trigger handling.

Parameters:
NUM_STAGES, 4, number of coil stages; must be ≥1.
CNT_W, 32, width of all cycle counters.
DUTY_W, 32, width of duty inputs and PWM counter.
PWM_PERIOD, 588000, PWM period in clk cycles; must be ≥2.
CHARGE_CYCLES, 100000000, cycles in CHARGE; must be ≥1.
FIRE_CYCLES, 50000, cycles each stage spends in FIRE; must be ≥1.
GAP_CYCLES, 10000, cycles between stage fires; must be ≥1.
COOLDOWN_CYCLES, 1000000, cycles in COOLDOWN; must be ≥1.

Ports:
clk  in  1  clock.
rst  in  1  reset; asynchronous, active-high.
trig  in  1  launch request; synchronous to clk, rising-edge sensitive.
abort  in  1  synchronous abort; returns the block to IDLE.
duty_idle  in  DUTY_W  PWM high-count used outside FIRE.
duty_fire  in  DUTY_W  PWM high-count used in FIRE.
charge_n  out  1  active-low charge enable; 0 only in CHARGE.
fire  out  NUM_STAGES  per-stage fire outputs; one-hot-or-zero.
pwm_out  out  1  raw PWM waveform.
busy  out  1  1 in any state other than IDLE.
stage_idx  out  max(1,$clog2(NUM_STAGES))  current stage number.
done  out  1  one-cycle pulse on normal completion.

Behaviour:
- Reset values: charge_n=1, fire=0, pwm_out=0, busy=0, stage_idx=0, done=0. Internal state: FSM=IDLE, trig_q=0, timer=0, pwm_cnt=0, duty_q=0.
- Edge detect: trig_q registers trig every cycle. A start is accepted when trig & ~trig_q & state==IDLE & ~abort.
  - A held trigger gives exactly one launch.
  - Edges while busy are discarded and are not queued.
- FSM states: IDLE, CHARGE, FIRE, GAP, COOLDOWN.
- IDLE→CHARGE: on the posedge where a start is accepted. Timer loads CHARGE_CYCLES-1.
- In CHARGE, FIRE, GAP and COOLDOWN the timer decrements each cycle. When the timer is 0, the FSM leaves the state on that edge. Each state therefore lasts exactly its parameter in cycles.
- CHARGE→FIRE: stage_idx=0.
- FIRE→GAP: taken if stage_idx<NUM_STAGES-1. On entering the next FIRE, stage_idx increments.
- FIRE→COOLDOWN: taken if stage_idx==NUM_STAGES-1. When NUM_STAGES=1 there is no GAP.
- GAP→FIRE.
- COOLDOWN→IDLE: done=1 for the single cycle in which state==IDLE after the transition. stage_idx returns to 0.
- Total busy length = CHARGE + N·FIRE + (N-1)·GAP + COOLDOWN cycles.
- charge_n = ~(state==CHARGE), registered or decoded from registered state; it has no glitch path.
- PWM counter:
  - pwm_cnt runs 0..PWM_PERIOD-1 and wraps to 0 in every state, including IDLE.
  - pwm_out = (pwm_cnt < duty_q). duty≥PWM_PERIOD gives constant 1; duty=0 gives constant 0.
- Duty reload:
  - At each wrap, duty_q reloads from duty_fire if state==FIRE, otherwise from duty_idle.
  - On every entry to FIRE, pwm_cnt is forced to 0 and duty_q loads duty_fire. Each stage therefore starts with a full fire period.
  - On exit from FIRE, pwm_cnt is forced to 0 and duty_q loads duty_idle.
  - Mid-period duty input changes take effect only at the next wrap or forced reload.
- fire[i] = pwm_out & (state==FIRE) & (stage_idx==i). All other bits are 0.
- abort has priority over every transition, including a simultaneous start. On the next edge:
  - state=IDLE, timer=0, stage_idx=0;
  - fire=0 and charge_n=1 from that edge onward;
  - pwm_cnt=0, duty_q=duty_idle;
  - done is not pulsed.
- Async rst mid-operation: all outputs take their reset values immediately, without waiting for an edge.
- Counter arithmetic is unsigned CNT_W/DUTY_W. Parameters must fit their counter width; this is checked by an elaboration assertion.

Test Plan:
Bench parameters: NUM_STAGES=3, CHARGE=10, FIRE=4, GAP=2, COOLDOWN=5, PWM_PERIOD=8, duty_idle=0, duty_fire=8.
1. Reset, then a 1-cycle trig pulse -> charge_n=0 for 10 cycles; fire[0], fire[1], fire[2] each high 4 cycles with 2-cycle zero gaps; stage_idx steps 0,1,2; busy high 31 cycles; done pulses exactly once, 1 cycle after busy falls.
2. trig held high for 100 cycles -> exactly one sequence (one done). A low-then-high edge afterwards starts a second sequence.
3. Extra trig edges during CHARGE, FIRE and COOLDOWN -> ignored; total done count stays 1.
4. duty_fire=3 -> each fire[i] window shows a pattern starting at period start: high 3, low 5 (repeat); truncated at 4 cycles per FIRE, so fire=1110 per stage. Changing duty_idle from 2 to 6 mid-period takes effect at the next wrap only. duty_idle=0 keeps pwm_out=0 in IDLE.
5. abort asserted in cycle 2 of stage 1 FIRE -> next edge: fire=0, busy=0, stage_idx=0, no done. A new trig edge then launches normally. abort coincident with a start -> no launch.
6. rst asserted asynchronously mid-CHARGE (between edges) -> charge_n=1, busy=0, pwm_out=0 immediately. After release, the FSM is in IDLE with no pending launch.
